// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared types and fixed lengths for the HDMI data-island scheduler
package hdmi_pkg;

  typedef enum logic [1:0] {
    CTRL        = 2'd0,
    DI_PREAMBLE = 2'd1,
    DI_GUARD    = 2'd2,
    DI_DATA     = 2'd3
  } period_t;

  localparam int REQ_AUDIO_SAMPLE = 0;
  localparam int REQ_ACR          = 1;
  localparam int REQ_AVI_INFO     = 2;
  localparam int REQ_AUDIO_INFO   = 3;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

  // A further packet needs its own 32 cycles plus the trailing guard before DI_LIMIT.
  localparam int NEXT_PACKET_SPAN = PACKET_LEN + GUARD_LEN;

endpackage

// File: rtl/hdmi_island_scheduler_if.sv
// rtl/hdmi_island_scheduler_if.sv - timing/requester side to scheduler bundle
interface hdmi_island_scheduler_if;
  import hdmi_pkg::*;

  logic [9:0] cx;
  logic [3:0] req;
  logic [3:0] gnt;
  period_t    period;
  logic [1:0] packet_sel;
  logic [4:0] packet_idx;

  modport master (
    output cx, req,
    input  gnt, period, packet_sel, packet_idx
  );

  modport slave (
    input  cx, req,
    output gnt, period, packet_sel, packet_idx
  );

endinterface

// File: rtl/hdmi_prio_arbiter.sv
// rtl/hdmi_prio_arbiter.sv - 4-way fixed-priority arbiter, index 0 wins
module hdmi_prio_arbiter
  import hdmi_pkg::*;
(
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_sel,
  output logic       o_valid
);

  always_comb begin
    o_gnt   = '0;
    o_sel   = '0;
    o_valid = |i_req;
    // Walk from lowest priority up so the highest-priority request is written last.
    for (int i = 3; i >= 0; i--) begin
      if (i_req[i]) begin
        o_gnt = 4'(1 << i);
        o_sel = 2'(i);
      end
    end
  end

endmodule

// File: rtl/hdmi_island_scheduler.sv
// rtl/hdmi_island_scheduler.sv - opens one data island per line after active video
// and packs prioritised packets into it until the requests, packet cap or line end run out.
module hdmi_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int SCREEN_WIDTH    = 720,
  parameter int FRAME_WIDTH     = 858,
  parameter int DI_START_OFFSET = 4,
  parameter int MAX_PACKETS     = 18
) (
  input logic                     clk_pixel,
  input logic                     reset,
  hdmi_island_scheduler_if.slave  bus
);

  localparam int DI_START = SCREEN_WIDTH + DI_START_OFFSET;
  localparam int DI_LIMIT = FRAME_WIDTH - 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_LEAD_GUARD,
    S_DATA,
    S_TRAIL_GUARD
  } state_t;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [4:0] r_pkt_cnt;
  period_t    r_period;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic [4:0] r_idx;

  logic [3:0]  w_arb_gnt;
  logic [1:0]  w_arb_sel;
  logic        w_arb_valid;
  logic [11:0] w_cx_end;
  logic        w_open;
  logic        w_lead_last;
  logic        w_data_last;
  logic        w_more;
  logic        w_issue;

  hdmi_prio_arbiter u_arb (
    .i_req   (bus.req),
    .o_gnt   (w_arb_gnt),
    .o_sel   (w_arb_sel),
    .o_valid (w_arb_valid)
  );

  assign w_cx_end    = {2'b00, bus.cx} + 12'(NEXT_PACKET_SPAN);
  assign w_open      = (bus.cx == 10'(DI_START)) && w_arb_valid;
  assign w_lead_last = (r_state == S_LEAD_GUARD) && (r_cnt == 3'(GUARD_LEN - 1));
  assign w_data_last = (r_state == S_DATA) && (r_idx == 5'(PACKET_LEN - 1));
  assign w_more      = w_arb_valid && (r_pkt_cnt < 5'(MAX_PACKETS)) && (w_cx_end <= 12'(DI_LIMIT));
  // A packet is only granted when someone still asks at the decision cycle.
  assign w_issue     = (w_lead_last && w_arb_valid) || (w_data_last && w_more);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pkt_cnt <= '0;
      r_period  <= CTRL;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_idx     <= '0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_idx     <= '0;
          r_pkt_cnt <= '0;
          if (w_open) begin
            r_state  <= S_PREAMBLE;
            r_period <= DI_PREAMBLE;
          end else begin
            r_period <= CTRL;
          end
        end
        S_PREAMBLE: begin
          if (r_cnt == 3'(PREAMBLE_LEN - 1)) begin
            r_cnt    <= '0;
            r_state  <= S_LEAD_GUARD;
            r_period <= DI_GUARD;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_LEAD_GUARD: begin
          if (w_lead_last) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_state  <= S_DATA;
            r_period <= DI_DATA;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_DATA: begin
          if (w_data_last) begin
            r_idx <= '0;
            if (!w_more) begin
              r_state  <= S_TRAIL_GUARD;
              r_period <= DI_GUARD;
            end
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
        S_TRAIL_GUARD: begin
          if (r_cnt == 3'(GUARD_LEN - 1)) begin
            r_cnt    <= '0;
            r_state  <= S_IDLE;
            r_period <= CTRL;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_period <= CTRL;
        end
      endcase

      if (w_issue) begin
        r_gnt <= w_arb_gnt;
        r_sel <= w_arb_sel;
        if (r_pkt_cnt != 5'd31) begin
          r_pkt_cnt <= r_pkt_cnt + 5'd1;
        end
      end
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.period     = r_period;
  assign bus.packet_sel = r_sel;
  assign bus.packet_idx = r_idx;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// tb/tb_hdmi_island_scheduler.sv - directed table-driven bench for hdmi_island_scheduler
module tb_hdmi_island_scheduler;
  import hdmi_pkg::*;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [9:0] cx_drv;
  logic [3:0] req_drv;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_island_scheduler_if bus1 ();
  hdmi_island_scheduler_if bus2 ();

  assign bus1.cx  = cx_drv;
  assign bus1.req = req_drv;
  assign bus2.cx  = cx_drv;
  assign bus2.req = req_drv;

  hdmi_island_scheduler dut1 (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus1)
  );

  hdmi_island_scheduler #(
    .FRAME_WIDTH (2000),
    .MAX_PACKETS (2)
  ) dut2 (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .bus       (bus2)
  );

  typedef struct {
    int         lo;
    int         hi;
    logic [3:0] req;
    logic       rst;
    period_t    per;
    logic [3:0] gnt;
    int         sel;
    int         idx0;
  } seg_t;

  seg_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic [3:0] dropped;
  bit   obey;
  bit   use2;
  int   gnt_seen;

  period_t    s_per;
  logic [3:0] s_gnt;
  logic [1:0] s_sel;
  logic [4:0] s_idx;

  task automatic add(input int lo, input int hi, input logic [3:0] r, input logic rs,
                     input period_t p, input logic [3:0] g, input int sel, input int idx0);
    tbl.push_back('{lo, hi, r, rs, p, g, sel, idx0});
  endtask

  task automatic open_island(input logic [3:0] r);
    add(725, 732, r, 1'b0, DI_PREAMBLE, 4'b0000, -1, 0);
    add(733, 734, r, 1'b0, DI_GUARD,    4'b0000, -1, 0);
  endtask

  task automatic pre(input logic [3:0] r);
    add(720, 724, r, 1'b0, CTRL, 4'b0000, -1, 0);
    open_island(r);
  endtask

  task automatic step(input int c, input logic [3:0] r, input logic rs);
    cx_drv  = 10'(c);
    req_drv = r;
    reset   = rs;
    @(negedge clk_pixel);
    if (use2) begin
      s_per = bus2.period; s_gnt = bus2.gnt; s_sel = bus2.packet_sel; s_idx = bus2.packet_idx;
    end else begin
      s_per = bus1.period; s_gnt = bus1.gnt; s_sel = bus1.packet_sel; s_idx = bus1.packet_idx;
    end
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cx=%0d: got %0d, expected %0d", name, c, got, exp);
    end
  endtask

  task automatic run_tbl();
    logic [3:0] r;
    dropped = '0;
    foreach (tbl[k]) begin
      for (int c = tbl[k].lo; c <= tbl[k].hi; c++) begin
        r = obey ? (tbl[k].req & ~dropped) : tbl[k].req;
        step(c, r, tbl[k].rst);
        chk("period", c, s_per, tbl[k].per);
        chk("gnt", c, s_gnt, tbl[k].gnt);
        chk("packet_idx", c, s_idx, (tbl[k].per == DI_DATA) ? (tbl[k].idx0 + c - tbl[k].lo) : 0);
        if (tbl[k].sel >= 0) chk("packet_sel", c, s_sel, tbl[k].sel);
        if (obey) dropped = dropped | s_gnt;
      end
    end
  endtask

  initial begin
    reset = 1'b1; cx_drv = '0; req_drv = '0; use2 = 1'b0; obey = 1'b0;

    step(0, 4'b0000, 1'b1);
    step(1, 4'b1111, 1'b1);
    step(2, 4'b0000, 1'b0);
    chk("reset_period", 2, s_per, CTRL);
    chk("reset_gnt", 2, s_gnt, 0);
    chk("reset_sel", 2, s_sel, 0);
    chk("reset_idx", 2, s_idx, 0);

    // Single audio packet, requester drops after its grant.
    tbl.delete(); obey = 1'b1;
    pre(4'b0001);
    add(735, 735, 4'b0001, 1'b0, DI_DATA, 4'b0001, 0, 0);
    add(736, 766, 4'b0001, 1'b0, DI_DATA, 4'b0000, 0, 1);
    add(767, 768, 4'b0001, 1'b0, DI_GUARD, 4'b0000, -1, 0);
    add(769, 775, 4'b0001, 1'b0, CTRL, 4'b0000, -1, 0);
    run_tbl();

    // All requests held: line end cuts the island after three packets.
    tbl.delete(); obey = 1'b0;
    pre(4'b1111);
    add(735, 735, 4'b1111, 1'b0, DI_DATA, 4'b0001, 0, 0);
    add(736, 766, 4'b1111, 1'b0, DI_DATA, 4'b0000, 0, 1);
    add(767, 767, 4'b1111, 1'b0, DI_DATA, 4'b0001, 0, 0);
    add(768, 798, 4'b1111, 1'b0, DI_DATA, 4'b0000, 0, 1);
    add(799, 799, 4'b1111, 1'b0, DI_DATA, 4'b0001, 0, 0);
    add(800, 830, 4'b1111, 1'b0, DI_DATA, 4'b0000, 0, 1);
    add(831, 832, 4'b1111, 1'b0, DI_GUARD, 4'b0000, -1, 0);
    add(833, 857, 4'b1111, 1'b0, CTRL, 4'b0000, -1, 0);
    run_tbl();

    // ACR then AVI, back to back.
    tbl.delete(); obey = 1'b1;
    pre(4'b0110);
    add(735, 735, 4'b0110, 1'b0, DI_DATA, 4'b0010, 1, 0);
    add(736, 766, 4'b0110, 1'b0, DI_DATA, 4'b0000, 1, 1);
    add(767, 767, 4'b0110, 1'b0, DI_DATA, 4'b0100, 2, 0);
    add(768, 798, 4'b0110, 1'b0, DI_DATA, 4'b0000, 2, 1);
    add(799, 800, 4'b0110, 1'b0, DI_GUARD, 4'b0000, -1, 0);
    add(801, 810, 4'b0110, 1'b0, CTRL, 4'b0000, -1, 0);
    run_tbl();

    // Request arrives one cycle late: island waits for the next line.
    tbl.delete(); obey = 1'b1;
    add(720, 724, 4'b0000, 1'b0, CTRL, 4'b0000, -1, 0);
    add(725, 857, 4'b0001, 1'b0, CTRL, 4'b0000, -1, 0);
    add(0, 724, 4'b0001, 1'b0, CTRL, 4'b0000, -1, 0);
    open_island(4'b0001);
    add(735, 735, 4'b0001, 1'b0, DI_DATA, 4'b0001, 0, 0);
    add(736, 766, 4'b0001, 1'b0, DI_DATA, 4'b0000, 0, 1);
    add(767, 768, 4'b0001, 1'b0, DI_GUARD, 4'b0000, -1, 0);
    add(769, 770, 4'b0001, 1'b0, CTRL, 4'b0000, -1, 0);
    run_tbl();

    // Reset in the middle of a packet.
    tbl.delete(); obey = 1'b0;
    pre(4'b0001);
    add(735, 735, 4'b0001, 1'b0, DI_DATA, 4'b0001, 0, 0);
    add(736, 744, 4'b0001, 1'b0, DI_DATA, 4'b0000, 0, 1);
    add(745, 745, 4'b0001, 1'b1, DI_DATA, 4'b0000, 0, 10);
    run_tbl();
    gnt_seen = 0;
    for (int c = 746; c <= 760; c++) begin
      step(c, 4'b0001, 1'b0);
      if (s_gnt != 4'b0000) gnt_seen++;
      chk("rst_period", c, s_per, CTRL);
      chk("rst_idx", c, s_idx, 0);
      if (c == 746) chk("rst_sel", c, s_sel, 0);
    end
    chk("rst_no_gnt", 760, gnt_seen, 0);
    tbl.delete(); obey = 1'b1;
    pre(4'b0001);
    add(735, 735, 4'b0001, 1'b0, DI_DATA, 4'b0001, 0, 0);
    add(736, 766, 4'b0001, 1'b0, DI_DATA, 4'b0000, 0, 1);
    add(767, 768, 4'b0001, 1'b0, DI_GUARD, 4'b0000, -1, 0);
    add(769, 770, 4'b0001, 1'b0, CTRL, 4'b0000, -1, 0);
    run_tbl();

    // Packet cap of two on a wide line.
    use2 = 1'b1; obey = 1'b0;
    step(0, 4'b0000, 1'b1);
    tbl.delete();
    pre(4'b0001);
    add(735, 735, 4'b0001, 1'b0, DI_DATA, 4'b0001, 0, 0);
    add(736, 766, 4'b0001, 1'b0, DI_DATA, 4'b0000, 0, 1);
    add(767, 767, 4'b0001, 1'b0, DI_DATA, 4'b0001, 0, 0);
    add(768, 798, 4'b0001, 1'b0, DI_DATA, 4'b0000, 0, 1);
    add(799, 800, 4'b0001, 1'b0, DI_GUARD, 4'b0000, -1, 0);
    add(801, 810, 4'b0001, 1'b0, CTRL, 4'b0000, -1, 0);
    run_tbl();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
